// File: rtl/calc_port_responder.sv
// Answering end of one calc2 port: two-cycle request capture, add/sub/shift compute,
// fixed-latency in-order response pipeline and outstanding-tag tracking.
module calc_port_responder #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 2,
  parameter int LATENCY = 3
) (
  input  logic                  c_clk,
  input  logic                  reset,
  input  logic [3:0]            req_cmd_in,
  input  logic [DATA_W-1:0]     req_data_in,
  input  logic [TAG_W-1:0]      req_tag_in,
  output logic [1:0]            out_resp,
  output logic [DATA_W-1:0]     out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic [2**TAG_W-1:0]   tags_busy,
  output logic                  err_dup_tag
);

  localparam int NTAGS = 2**TAG_W;

  typedef enum logic {IDLE, OP2} state_t;

  state_t state, state_nxt;

  logic [3:0]        cmd_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic [TAG_W-1:0]  tag_q;
  logic              dup_q;
  logic              comp_valid;

  logic [1:0]        res_resp;
  logic [DATA_W-1:0] res_data;
  logic [DATA_W:0]   sum;

  logic [NTAGS-1:0]  release_vec;
  logic [NTAGS-1:0]  set_vec;
  logic              capture;
  logic              cap_dup;

  logic [1:0]        pipe_resp [LATENCY];
  logic [DATA_W-1:0] pipe_data [LATENCY];
  logic [TAG_W-1:0]  pipe_tag  [LATENCY];
  logic              pipe_dup  [LATENCY];

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_cmd_in != 4'd0) state_nxt = OP2;
      OP2:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign capture = (state == IDLE) && (req_cmd_in != 4'd0);

  // A tag frees only when its original (non-duplicate) response is on the outputs.
  always_comb begin
    release_vec = '0;
    set_vec     = '0;
    if (out_resp != 2'd0 && !err_dup_tag) release_vec[out_tag] = 1'b1;
    if (capture) set_vec[req_tag_in] = 1'b1;
  end

  assign cap_dup = tags_busy[req_tag_in] && !release_vec[req_tag_in];

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      cmd_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      tag_q      <= '0;
      dup_q      <= 1'b0;
      comp_valid <= 1'b0;
      tags_busy  <= '0;
    end else begin
      if (capture) begin
        cmd_q <= req_cmd_in;
        op1_q <= req_data_in;
        tag_q <= req_tag_in;
        dup_q <= cap_dup;
      end
      if (state == OP2) op2_q <= req_data_in;
      comp_valid <= (state == OP2);
      tags_busy  <= (tags_busy & ~release_vec) | set_vec;
    end
  end

  always_comb begin
    res_resp = 2'd2;
    res_data = '0;
    sum      = {1'b0, op1_q} + {1'b0, op2_q};
    case (cmd_q)
      4'd1: if (!sum[DATA_W]) begin
              res_resp = 2'd1;
              res_data = sum[DATA_W-1:0];
            end
      4'd2: if (op1_q >= op2_q) begin
              res_resp = 2'd1;
              res_data = op1_q - op2_q;
            end
      4'd5: begin
              res_resp = 2'd1;
              res_data = op1_q << op2_q[4:0];
            end
      4'd6: begin
              res_resp = 2'd1;
              res_data = op1_q >> op2_q[4:0];
            end
      default: ;
    endcase
    if (dup_q) begin
      res_resp = 2'd2;
      res_data = '0;
    end
  end

  // Empty slots carry all-zero fields so the outputs never show stale data.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_resp[i] <= '0;
        pipe_data[i] <= '0;
        pipe_tag[i]  <= '0;
        pipe_dup[i]  <= 1'b0;
      end
    end else begin
      if (comp_valid) begin
        pipe_resp[0] <= res_resp;
        pipe_data[0] <= res_data;
        pipe_tag[0]  <= tag_q;
        pipe_dup[0]  <= dup_q;
      end else begin
        pipe_resp[0] <= '0;
        pipe_data[0] <= '0;
        pipe_tag[0]  <= '0;
        pipe_dup[0]  <= 1'b0;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_resp[i] <= pipe_resp[i-1];
        pipe_data[i] <= pipe_data[i-1];
        pipe_tag[i]  <= pipe_tag[i-1];
        pipe_dup[i]  <= pipe_dup[i-1];
      end
    end
  end

  assign out_resp    = pipe_resp[LATENCY-1];
  assign out_data    = pipe_data[LATENCY-1];
  assign out_tag     = pipe_tag[LATENCY-1];
  assign err_dup_tag = pipe_dup[LATENCY-1];

endmodule

// File: tb/tb_calc_port_responder.sv
// Self-checking bench for calc_port_responder: directed scenarios plus random traffic,
// compared every cycle against a cycle-numbered reference model of responses and tag lifetimes.
module tb_calc_port_responder;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 2;
  localparam int LAT    = 3;
  localparam int NT     = 4;

  logic              c_clk = 1'b0;
  logic              reset;
  logic [3:0]        req_cmd_in;
  logic [DATA_W-1:0] req_data_in;
  logic [TAG_W-1:0]  req_tag_in;
  logic [1:0]        out_resp;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [NT-1:0]     tags_busy;
  logic              err_dup_tag;

  always #5 c_clk = ~c_clk;

  calc_port_responder #(.DATA_W(DATA_W), .TAG_W(TAG_W), .LATENCY(LAT)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .req_tag_in  (req_tag_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .tags_busy   (tags_busy),
    .err_dup_tag (err_dup_tag)
  );

  typedef struct {
    int          at;
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
    logic        dup;
  } exp_t;

  exp_t        exp_q[$];
  int          edge_n = 0;
  int          rel_edge[NT];
  bit          pend = 1'b0;
  logic [3:0]  p_cmd;
  logic [31:0] p_op1;
  logic [1:0]  p_tag;
  bit          p_dup;
  int          checks = 0;
  int          errors = 0;

  // Expected response from plain arithmetic on the request, response due at edge 'at'.
  function automatic exp_t ref_result(input logic [3:0] cmd, input logic [31:0] op1,
                                      input logic [31:0] op2, input logic [1:0] tag,
                                      input bit dup, input int at);
    exp_t r;
    longint unsigned a, b, sh;
    a = 64'(op1);
    b = 64'(op2);
    sh = 64'(op2 % 32);
    r.at = at; r.tag = tag; r.dup = dup; r.resp = 2'd2; r.data = 32'd0;
    if (!dup) begin
      case (cmd)
        4'd1: if (a + b <= 64'hFFFF_FFFF) begin r.resp = 2'd1; r.data = 32'(a + b); end
        4'd2: if (a >= b) begin r.resp = 2'd1; r.data = 32'(a - b); end
        4'd5: begin r.resp = 2'd1; r.data = 32'((a * (64'd1 << sh)) % 64'h1_0000_0000); end
        4'd6: begin r.resp = 2'd1; r.data = 32'(a / (64'd1 << sh)); end
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h at edge %0d", name, obs, expv, edge_n);
    end
  endtask

  task automatic check_output();
    exp_t e;
    logic [NT-1:0] busy_exp;
    e = '{at: 0, resp: 2'd0, data: 32'd0, tag: 2'd0, dup: 1'b0};
    if (exp_q.size() > 0 && exp_q[0].at == edge_n) e = exp_q.pop_front();
    for (int t = 0; t < NT; t++) busy_exp[t] = (rel_edge[t] > edge_n);
    check_val("out_resp",    32'(out_resp),    32'(e.resp));
    check_val("out_data",    out_data,         e.data);
    check_val("out_tag",     32'(out_tag),     32'(e.tag));
    check_val("err_dup_tag", 32'(err_dup_tag), 32'(e.dup));
    check_val("tags_busy",   32'(tags_busy),   32'(busy_exp));
  endtask

  // What the port does at one rising edge, in request/tag-lifetime terms.
  task automatic model_edge(input logic [3:0] cmd, input logic [31:0] data, input logic [1:0] tag);
    if (reset == 1'b0) return;
    if (pend) begin
      exp_q.push_back(ref_result(p_cmd, p_op1, data, p_tag, p_dup, edge_n + LAT));
      pend = 1'b0;
    end else if (cmd != 4'd0) begin
      p_dup = (rel_edge[tag] > edge_n);
      if (!p_dup) rel_edge[tag] = edge_n + LAT + 2;
      p_cmd = cmd; p_op1 = data; p_tag = tag; pend = 1'b1;
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] cmd, input logic [31:0] data, input logic [1:0] tag);
    req_cmd_in = cmd; req_data_in = data; req_tag_in = tag;
    @(posedge c_clk);
    edge_n++;
    model_edge(cmd, data, tag);
    @(negedge c_clk);
    check_output();
  endtask

  task automatic send(input logic [3:0] cmd, input logic [1:0] tag,
                      input logic [31:0] op1, input logic [31:0] op2);
    apply_stimulus(cmd, op1, tag);
    apply_stimulus(4'($urandom_range(1, 15)), op2, 2'($urandom));
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(4'd0, $urandom, 2'($urandom));
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend = 1'b0;
    for (int t = 0; t < NT; t++) rel_edge[t] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_output();
    idle(2);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] cmds [7];
    logic [31:0] a, b;
    cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd7, 4'd15};
    reset = 1'b0; req_cmd_in = '0; req_data_in = '0; req_tag_in = '0;
    model_reset();
    #1;
    check_output();
    idle(2);
    reset = 1'b1;
    idle(1);

    $display("[TB] add");
    send(4'd1, 2'd2, 32'h10, 32'h22);
    idle(3);
    check_val("t1_data_const", out_data, 32'h32);
    check_val("t1_tag_const", 32'(out_tag), 32'd2);
    idle(1);
    check_val("t1_busy2_cleared", 32'(tags_busy[2]), 32'd0);
    idle(2);

    $display("[TB] overflow and underflow");
    send(4'd1, 2'd0, 32'hFFFF_FFFF, 32'h1);
    send(4'd2, 2'd1, 32'd5, 32'd6);
    send(4'd2, 2'd3, 32'd6, 32'd5);
    idle(5);

    $display("[TB] shifts and invalid");
    send(4'd5, 2'd0, 32'h1, 32'h21);
    send(4'd6, 2'd1, 32'h8000_0000, 32'd31);
    send(4'd3, 2'd2, 32'h1234, 32'h5);
    idle(5);

    $display("[TB] back-to-back tags");
    for (int t = 0; t < NT; t++) send(4'd1, 2'(t), $urandom_range(0, 1000), $urandom_range(0, 1000));
    idle(6);

    $display("[TB] duplicate tag");
    send(4'd1, 2'd1, 32'd100, 32'd23);
    send(4'd2, 2'd1, 32'd50, 32'd7);
    idle(1);
    send(4'd2, 2'd1, 32'd50, 32'd7);
    idle(6);

    $display("[TB] reset with responses pending");
    send(4'd1, 2'd0, 32'd1, 32'd2);
    send(4'd2, 2'd1, 32'd9, 32'd4);
    apply_stimulus(4'd1, 32'd3, 2'd2);
    do_reset();
    idle(6);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 2));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - a + 32'($urandom_range(0, 2))) : $urandom;
      send(cmds[$urandom_range(0, 6)], 2'($urandom), a, b);
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
